mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 15, the memory word width.
REQ-002 Parameter ADDR_W, default 3, the memory address width (8 entries).
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Ports req0/req1, input, 1 each: request from requester 0/1, held high until the matching gnt pulse.
REQ-006 Ports we0/we1, input, 1 each: 1 for write, 0 for read; sampled together with the addr/wdata ports at acceptance.
REQ-007 Ports addr0/addr1, input, ADDR_W each: target address.
REQ-008 Ports wdata0/wdata1, input, DATA_W each: write data.
REQ-009 Ports gnt0/gnt1, output, 1 each: one-cycle pulse meaning the command is captured and the requester may drop req.
REQ-010 Ports done0/done1, output, 1 each: one-cycle pulse meaning the access is complete and rdata is valid.
REQ-011 Port rdata, output, DATA_W: memory word returned with done (stored value after a write, read value after a read).
REQ-012 Port clr, input, 1: request to clear all memory contents.
REQ-013 Port clr_done, output, 1: one-cycle pulse meaning the clear is complete.
REQ-014 Port busy, output, 1: high in every state except IDLE.
REQ-015 Ports mem_addr, mem_wdata, mem_we and mem_rst, outputs (ADDR_W, DATA_W, 1, 1): these drive the memory addr, in_data, we and rst inputs.
REQ-016 Port mem_rdata, input, DATA_W: the memory out_data, which is valid the cycle after an address or write is presented.

Function
REQ-017 The FSM SHALL have the states IDLE, ACCESS, RESPOND and CLEAR, all registered.
REQ-018 In IDLE with clr=1, the block SHALL go to CLEAR, regardless of req0/req1 (clr has top priority).
REQ-019 In IDLE with clr=0 and any req high, the block SHALL select a winner, capture that requester's we/addr/wdata into internal registers, and go to ACCESS.
REQ-020 Selection SHALL be round-robin: a single request wins outright; when both requests are high, the requester named by the priority pointer ptr wins.
REQ-021 ACCESS SHALL last one cycle: the captured addr/wdata are driven on mem_addr/mem_wdata, mem_we equals the captured we, and gnt of the winner is 1; the block then goes to RESPOND.
REQ-022 RESPOND SHALL last one cycle: rdata equals mem_rdata and done of the winner is 1; ptr is set to the other requester and the block returns to IDLE.
REQ-023 CLEAR SHALL last one cycle: mem_rst=1 and clr_done=1; the block then returns to IDLE and ptr is unchanged.
REQ-024 mem_we SHALL be 1 only during an ACCESS write and mem_rst SHALL be 1 only during CLEAR; both are 0 in all other cycles.
REQ-025 Request-to-done latency SHALL be 3 cycles (accept edge, ACCESS, RESPOND), and a new acceptance is possible in the cycle after RESPOND.
REQ-026 Under continuous contention, grants SHALL strictly alternate between the two requesters, so neither starves.
REQ-027 Requests, clr and the command inputs SHALL be ignored outside IDLE, and a clr arriving mid-access is served at the next IDLE.
REQ-028 When no gnt, done or clr_done is active, rdata SHALL hold its last value.
REQ-029 Requester inputs SHALL be captured only at acceptance, so changing them during ACCESS has no effect.

Reset
REQ-030 When rst=1 at a clock edge, the block SHALL go to IDLE, set ptr to requester 0, and clear the captured registers.
REQ-031 During reset, all outputs SHALL be 0: gnt, done, clr_done, busy, mem_we, mem_rst, mem_addr, mem_wdata and rdata.
REQ-032 A reset during ACCESS or RESPOND SHALL abandon the access: no done is issued and mem_we is 0 from the cycle after the reset edge.
REQ-033 rst SHALL not drive mem_rst; the memory is cleared only through clr.

Verification
REQ-034 Single write then read: req0 writes addr 3 with data 15'd2747, then req0 reads addr 3 -> each access has gnt0 exactly 2 cycles and done0 exactly 3 cycles after acceptance, and the read returns rdata=15'd2747.
REQ-035 Contention: req0 and req1 held high for 4 accesses after reset -> grant order is 0,1,0,1, and each done is matched to its own requester and data.
REQ-036 Full sweep: write 15'd2747, 7503, 29928, 4993, 27060, 17640, 32641 and 2562 to addresses 0-7, then read addresses 0-7 -> all eight values match, and mem_we pulses exactly 8 times.
REQ-037 Clear priority: clr, req0 and req1 all high in IDLE -> mem_rst pulses first with clr_done, and a later read of every address returns rdata=0.
REQ-038 Reset mid-access: assert rst during the ACCESS cycle of a write -> no done0, mem_we is 0 in the next cycle, busy=0, and ptr selects requester 0 on the next contention.
REQ-039 Late clr: raise clr during RESPOND -> it is ignored until IDLE, then CLEAR is entered on the next cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter in front of a single-port
// memory with a one-cycle read latency, plus a whole-memory clear command.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   req0/req1            requests, held until the matching gnt pulse
//   we0/we1              1 = write, 0 = read (captured at acceptance)
//   addr0/addr1          target address (captured at acceptance)
//   wdata0/wdata1        write data (captured at acceptance)
//   gnt0/gnt1            one-cycle pulse: command captured, req may drop
//   done0/done1          one-cycle pulse: access complete, rdata valid
//   rdata                word returned with done, held otherwise
//   clr, clr_done        clear request / one-cycle completion pulse
//   busy                 high whenever the controller is not idle
//   mem_addr, mem_wdata  memory address / write data
//   mem_we, mem_rst      memory write enable / clear
//   mem_rdata            memory read data, valid the cycle after presentation
//
// Timing per access: acceptance edge -> ACCESS (gnt, memory command)
// -> RESPOND (done, rdata) -> IDLE.
module mem_arbiter #(
  parameter int DATA_W = 15,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              clr,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              clr_done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_rst,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND, CLEAR} state_t;

  state_t            state;
  logic              ptr;      // requester favoured when both ask
  logic              win;      // requester owning the access in flight
  logic              pick;     // winner chosen this cycle (1 = requester 1)
  logic [DATA_W-1:0] rdata_q;  // last returned word

  // A lone request wins outright; on contention the pointer decides.
  assign pick = req1 & (~req0 | ptr);

  // Memory data is only valid during RESPOND, so it is passed straight
  // through there and remembered for the idle cycles that follow.
  assign rdata = (state == RESPOND) ? mem_rdata : rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      win       <= 1'b0;
      rdata_q   <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      clr_done  <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_rst   <= 1'b0;
    end else begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      clr_done <= 1'b0;
      mem_we   <= 1'b0;
      mem_rst  <= 1'b0;
      case (state)
        IDLE: begin
          if (clr) begin
            state    <= CLEAR;
            mem_rst  <= 1'b1;
            clr_done <= 1'b1;
            busy     <= 1'b1;
          end else if (req0 | req1) begin
            // mem_addr/mem_wdata double as the captured command registers.
            state     <= ACCESS;
            win       <= pick;
            mem_addr  <= pick ? addr1  : addr0;
            mem_wdata <= pick ? wdata1 : wdata0;
            mem_we    <= pick ? we1    : we0;
            gnt0      <= ~pick;
            gnt1      <= pick;
            busy      <= 1'b1;
          end
        end
        ACCESS: begin
          state <= RESPOND;
          done0 <= ~win;
          done1 <= win;
        end
        RESPOND: begin
          state   <= IDLE;
          ptr     <= ~win;
          rdata_q <= mem_rdata;
          busy    <= 1'b0;
        end
        CLEAR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
